control_paquetes: RTL

CONTROL_PAQUETES -- requirements
Module: control_paquetes

---
 rtl/control_paquetes.sv | 130 +++++++++++++
 1 files changed

// File: rtl/control_paquetes.sv
// Byte-to-word packet assembler: collects four bytes into a 32-bit word and
// hands it off. Optional partial-packet timeout under CTRL_PAQUETES_TIMEOUT_EN.

// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | no bytes held, sel=0, ready for the first byte
// S_COLLECT | 1..3 bytes held, waiting for the rest of the packet
// S_HOLD    | 4 bytes held, word_valid=1, waiting for word_ready

module control_paquetes #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic [1:0]  sel,
  output logic [7:0]  pkt_count,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sel;
  logic [31:0] r_word;
  logic [7:0]  r_pkt_count;
  logic        w_accept;
  logic        w_handoff;
  logic        w_timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("control_paquetes: TIMEOUT_CYCLES must be within 1..255");
  end

  assign byte_ready = (r_state != S_HOLD);
  assign w_accept   = byte_valid && byte_ready;
  assign w_handoff  = (r_state == S_HOLD) && word_ready;

`ifdef CTRL_PAQUETES_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_to_cnt;
  logic       r_timeout;

  // The edge that would bring the counter to TIMEOUT_CYCLES is the one that aborts.
  assign w_timeout_hit = (r_state == S_COLLECT) && !w_accept && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt  <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if ((r_state != S_COLLECT) || w_accept || w_timeout_hit) begin
        r_to_cnt <= 8'd0;
      end else begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_timeout_hit) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept && (r_sel == 2'd3)) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (word_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slots not rewritten keep stale bytes; only the word under word_valid matters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel       <= 2'd0;
      r_word      <= 32'd0;
      r_pkt_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_word[{r_sel, 3'b000} +: 8] <= byte_in;
        r_sel                        <= r_sel + 2'd1;
      end else if (w_timeout_hit) begin
        r_sel <= 2'd0;
      end
      if (w_handoff) begin
        r_pkt_count <= r_pkt_count + 8'd1;
      end
    end
  end

  assign word_valid = (r_state == S_HOLD);
  assign word_out   = r_word;
  assign sel        = r_sel;
  assign pkt_count  = r_pkt_count;

endmodule
